// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and encodings for the data-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - round-robin grant selection honouring the lock owner
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic       Req0,
    input  logic       Req1,
    input  logic       LastGnt,
    input  arb_state_t state,
    output logic       Gnt0,
    output logic       Gnt1
);

    always_comb begin
        Gnt0 = 1'b0;
        Gnt1 = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (Req0 && Req1) begin
                    Gnt0 = (LastGnt == PORT1);
                    Gnt1 = (LastGnt == PORT0);
                end else begin
                    Gnt0 = Req0;
                    Gnt1 = Req1;
                end
            end
            // the lock owner is the only candidate; the other port waits silently
            ARB_LOCK0: Gnt0 = Req0;
            ARB_LOCK1: Gnt1 = Req1;
            default: begin
                Gnt0 = 1'b0;
                Gnt1 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for the single-port data memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int W        = 8,
    parameter int A        = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Req0,
    input  logic         Req1,
    input  logic         We0,
    input  logic         We1,
    input  logic         Lock0,
    input  logic         Lock1,
    input  logic [A-1:0] Addr0,
    input  logic [A-1:0] Addr1,
    input  logic [W-1:0] WData0,
    input  logic [W-1:0] WData1,
    output logic         Gnt0,
    output logic         Gnt1,
    output logic         RValid0,
    output logic         RValid1,
    output logic [W-1:0] RData0,
    output logic [W-1:0] RData1,
    output logic [A-1:0] MemAddr,
    output logic         MemWriteEn,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut,
    output logic         LockActive
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    arb_state_t state, state_next;
    logic       last_gnt, last_gnt_next;
    logic [7:0] lock_cnt, lock_cnt_next;

    arb_rr_pick u_pick (
        .Req0    (Req0),
        .Req1    (Req1),
        .LastGnt (last_gnt),
        .state   (state),
        .Gnt0    (Gnt0),
        .Gnt1    (Gnt1)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ARB_IDLE;
            last_gnt <= PORT1;
            lock_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        case (state)
            ARB_IDLE: begin
                if (Gnt0 && Lock0) begin
                    state_next    = ARB_LOCK0;
                    lock_cnt_next = 8'd1;
                end else if (Gnt1 && Lock1) begin
                    state_next    = ARB_LOCK1;
                    lock_cnt_next = 8'd1;
                end
            end
            ARB_LOCK0: begin
                if (Req0 && Lock0 && (lock_cnt < MAX_LOCK_C)) begin
                    lock_cnt_next = lock_cnt + 8'd1;
                end else begin
                    state_next    = ARB_IDLE;
                    lock_cnt_next = 8'd0;
                end
            end
            ARB_LOCK1: begin
                if (Req1 && Lock1 && (lock_cnt < MAX_LOCK_C)) begin
                    lock_cnt_next = lock_cnt + 8'd1;
                end else begin
                    state_next    = ARB_IDLE;
                    lock_cnt_next = 8'd0;
                end
            end
            default: begin
                state_next    = ARB_IDLE;
                lock_cnt_next = 8'd0;
            end
        endcase
    end

    // a lock only ever grants its owner, so leaving it keeps LastGnt on the owner
    always_comb begin
        last_gnt_next = last_gnt;
        if (Gnt0) begin
            last_gnt_next = PORT0;
        end else if (Gnt1) begin
            last_gnt_next = PORT1;
        end
    end

    always_comb begin
        MemAddr    = '0;
        MemDataIn  = '0;
        MemWriteEn = 1'b0;
        if (Gnt0) begin
            MemAddr    = Addr0;
            MemDataIn  = WData0;
            MemWriteEn = We0;
        end else if (Gnt1) begin
            MemAddr    = Addr1;
            MemDataIn  = WData1;
            MemWriteEn = We1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RValid0 <= 1'b0;
            RValid1 <= 1'b0;
            RData0  <= '0;
            RData1  <= '0;
        end else begin
            RValid0 <= Gnt0 && !We0;
            RValid1 <= Gnt1 && !We1;
            if (Gnt0 && !We0) begin
                RData0 <= MemDataOut;
            end
            if (Gnt1 && !We1) begin
                RData1 <= MemDataOut;
            end
        end
    end

    assign LockActive = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Req0, Req1, We0, We1, Lock0, Lock1;
    logic [7:0] Addr0, Addr1, WData0, WData1;
    logic       Gnt0, Gnt1, RValid0, RValid1;
    logic [7:0] RData0, RData1;
    logic [7:0] MemAddr, MemDataIn, MemDataOut;
    logic       MemWriteEn, LockActive;

    logic [7:0] mem [256];
    logic       init_done = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.W(8), .A(8), .MAX_LOCK(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req0       (Req0),
        .Req1       (Req1),
        .We0        (We0),
        .We1        (We1),
        .Lock0      (Lock0),
        .Lock1      (Lock1),
        .Addr0      (Addr0),
        .Addr1      (Addr1),
        .WData0     (WData0),
        .WData1     (WData1),
        .Gnt0       (Gnt0),
        .Gnt1       (Gnt1),
        .RValid0    (RValid0),
        .RValid1    (RValid1),
        .RData0     (RData0),
        .RData1     (RData1),
        .MemAddr    (MemAddr),
        .MemWriteEn (MemWriteEn),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut),
        .LockActive (LockActive)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem[8'h10] <= 8'hA5;
            mem[8'h05] <= 8'h3C;
            init_done  <= 1'b1;
        end else if (MemWriteEn) begin
            mem[MemAddr] <= MemDataIn;
        end
    end

    assign MemDataOut = mem[MemAddr];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Req0 = 0; Req1 = 0; We0 = 0; We1 = 0; Lock0 = 0; Lock1 = 0;
        Addr0 = 0; Addr1 = 0; WData0 = 0; WData1 = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk1("rst_rvalid0", RValid0, 1'b0);
        chk1("rst_rvalid1", RValid1, 1'b0);
        chk8("rst_rdata0", RData0, 8'h00);
        chk1("rst_lockactive", LockActive, 1'b0);
        chk1("rst_memwe", MemWriteEn, 1'b0);
        Reset = 1'b0;

        // single read by port 0
        Req0 = 1; We0 = 0; Addr0 = 8'h10;
        #1;
        chk1("rd_gnt0", Gnt0, 1'b1);
        chk1("rd_gnt1", Gnt1, 1'b0);
        chk8("rd_memaddr", MemAddr, 8'h10);
        chk1("rd_memwe", MemWriteEn, 1'b0);
        cyc;
        Req0 = 0;
        #1;
        chk1("rd_rvalid0", RValid0, 1'b1);
        chk8("rd_rdata0", RData0, 8'hA5);
        chk1("rd_rvalid1", RValid1, 1'b0);
        cyc;
        chk1("rd_rvalid0_pulse", RValid0, 1'b0);
        chk8("rd_rdata0_held", RData0, 8'hA5);

        // contending writes alternate starting with port 0 after reset
        Reset = 1'b1; #1; Reset = 1'b0; #1;
        Req0 = 1; We0 = 1; Addr0 = 8'h01; WData0 = 8'h11;
        Req1 = 1; We1 = 1; Addr1 = 8'h02; WData1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1($sformatf("rr_gnt0_%0d", k), Gnt0, (k % 2) == 0);
            chk1($sformatf("rr_gnt1_%0d", k), Gnt1, (k % 2) == 1);
            chk1($sformatf("rr_memwe_%0d", k), MemWriteEn, 1'b1);
            chk8($sformatf("rr_memdin_%0d", k), MemDataIn, (k % 2) == 0 ? 8'h11 : 8'h22);
            cyc;
        end
        Req0 = 0; Req1 = 0; We0 = 0; We1 = 0;
        #1;
        chk8("rr_mem1", mem[8'h01], 8'h11);
        chk8("rr_mem2", mem[8'h02], 8'h22);

        // port 1 locks, port 0 waits until the unlocked write releases
        Req1 = 1; Lock1 = 1; We1 = 0; Addr1 = 8'h05;
        #1;
        chk1("lk_entry_gnt1", Gnt1, 1'b1);
        chk1("lk_entry_gnt0", Gnt0, 1'b0);
        cyc;
        Req0 = 1; We0 = 0; Addr0 = 8'h20;
        #1;
        chk1("lk_active", LockActive, 1'b1);
        chk1("lk_rvalid1", RValid1, 1'b1);
        chk8("lk_rdata1", RData1, 8'h3C);
        chk1("lk_rd_gnt1", Gnt1, 1'b1);
        chk1("lk_rd_gnt0", Gnt0, 1'b0);
        cyc;
        We1 = 1; WData1 = 8'h06; Lock1 = 0;
        #1;
        chk1("lk_wr_gnt1", Gnt1, 1'b1);
        chk1("lk_wr_gnt0", Gnt0, 1'b0);
        chk8("lk_wr_addr", MemAddr, 8'h05);
        chk8("lk_wr_din", MemDataIn, 8'h06);
        cyc;
        Req1 = 0; We1 = 0;
        #1;
        chk1("lk_released", LockActive, 1'b0);
        chk1("lk_after_gnt0", Gnt0, 1'b1);
        chk8("lk_mem5", mem[8'h05], 8'h06);
        cyc;
        Req0 = 0;
        #1;
        chk1("lk_after_rvalid0", RValid0, 1'b1);
        chk8("lk_after_rdata0", RData0, 8'h20);

        // forced release after MAX_LOCK grants inside the lock
        Reset = 1'b1; #1; Reset = 1'b0; #1;
        Req0 = 1; Lock0 = 1; We0 = 0; Addr0 = 8'h10;
        Req1 = 1; Lock1 = 0; We1 = 0; Addr1 = 8'h02;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1($sformatf("ml_gnt0_%0d", k), Gnt0, 1'b1);
            chk1($sformatf("ml_gnt1_%0d", k), Gnt1, 1'b0);
            chk1($sformatf("ml_lockactive_%0d", k), LockActive, k != 0);
            cyc;
        end
        chk1("ml_idle", LockActive, 1'b0);
        chk1("ml_next_gnt1", Gnt1, 1'b1);
        chk1("ml_next_gnt0", Gnt0, 1'b0);
        chk8("ml_rdata0", RData0, 8'hA5);
        cyc;
        chk1("ml_rvalid1", RValid1, 1'b1);
        chk8("ml_rdata1", RData1, 8'h22);
        chk1("ml_back_gnt0", Gnt0, 1'b1);
        cyc;

        // asynchronous reset while locked with a read return pending
        chk1("ar_pre_lock", LockActive, 1'b1);
        chk1("ar_pre_rvalid0", RValid0, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        chk1("ar_rvalid0", RValid0, 1'b0);
        chk1("ar_lockactive", LockActive, 1'b0);
        chk8("ar_rdata0", RData0, 8'h00);
        Lock0 = 0;
        Reset = 1'b0;
        #1;
        chk1("ar_tie_gnt0", Gnt0, 1'b1);
        chk1("ar_tie_gnt1", Gnt1, 1'b0);
        cyc;

        // idle bus drives zeros and leaves memory alone
        Req0 = 0; Req1 = 0;
        We0 = 1; Addr0 = 8'h33; WData0 = 8'h77;
        We1 = 1; Addr1 = 8'h44; WData1 = 8'h88;
        #1;
        chk1("id_gnt0", Gnt0, 1'b0);
        chk1("id_gnt1", Gnt1, 1'b0);
        chk1("id_memwe", MemWriteEn, 1'b0);
        chk8("id_memaddr", MemAddr, 8'h00);
        chk8("id_memdin", MemDataIn, 8'h00);
        repeat (3) cyc;
        chk8("id_mem1", mem[8'h01], 8'h11);
        chk8("id_mem5", mem[8'h05], 8'h06);
        chk8("id_mem33", mem[8'h33], 8'h33);
        chk8("id_mem44", mem[8'h44], 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
